// File: rtl/data_mux_reg_if.sv
// Bus bundle for the registered 3-input data selector: select code, three data
// sources, and the registered data/error outputs.
interface data_mux_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
) ();

  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] data_out;
  logic             sel_err;

  // Master drives the select and data sources and observes the registered result.
  modport master (
    output sel,
    output d0,
    output d1,
    output d2,
    input  data_out,
    input  sel_err
  );

  modport slave (
    input  sel,
    input  d0,
    input  d1,
    input  d2,
    output data_out,
    output sel_err
  );

endinterface

// File: rtl/data_mux_reg.sv
// Registered 3-input data selector. Illegal select codes hold the output and
// raise a non-sticky error flag for that cycle.
module data_mux_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
) (
  input logic             clk,
  input logic             rst,
  data_mux_reg_if.slave   bus
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  always_comb begin
    data_d = data_q;
    err_d  = 1'b0;
    unique case (bus.sel)
      SEL_W'(0): data_d = bus.d0;
      SEL_W'(1): data_d = bus.d1;
      SEL_W'(2): data_d = bus.d2;
      // Codes 3..7: keep the previous word, flag the bad select.
      default:   err_d  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.sel_err  = err_q;

endmodule

// File: tb/tb_data_mux_reg.sv
// Self-checking bench for data_mux_reg: directed cases followed by randomized
// stimulus compared against a behavioural model of the selector.
module tb_data_mux_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SEL_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  data_mux_reg_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  data_mux_reg #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned      n_vec = 0;
  int unsigned      n_mis = 0;
  logic [WIDTH-1:0] exp_data;
  logic             exp_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    bus.sel = s;
    bus.d0  = a;
    bus.d1  = b;
    bus.d2  = c;
  endtask

  task automatic check_outs(input string tag);
    check_eq({tag, "_data"}, 32'(bus.data_out), 32'(exp_data));
    check_eq({tag, "_err"}, 32'(bus.sel_err), 32'(exp_err));
  endtask

  // One rising edge: update the model from the values present at the edge, then
  // compare 1 time unit later.
  task automatic step(input string tag);
    logic [WIDTH-1:0] src [3];
    @(posedge clk);
    src = '{bus.d0, bus.d1, bus.d2};
    if (rst) begin
      exp_data = '0;
      exp_err  = 1'b0;
    end else if (int'(bus.sel) < 3) begin
      exp_data = src[int'(bus.sel)];
      exp_err  = 1'b0;
    end else begin
      exp_err  = 1'b1;
    end
    #1;
    check_outs(tag);
  endtask

  initial begin
    drive(3'($urandom_range(7)), 8'($urandom), 8'($urandom), 8'($urandom));
    // Asynchronous reset, asserted away from any clock edge.
    #2 rst = 1'b1;
    #1;
    exp_data = '0;
    exp_err  = 1'b0;
    check_outs("reset");
    check_eq("reset_const", 32'(bus.data_out), 32'h00);
    @(negedge clk);
    rst = 1'b0;

    drive(3'd0, 8'hAA, 8'h55, 8'hFF);
    step("sel0");
    check_eq("sel0_const", 32'(bus.data_out), 32'hAA);
    bus.sel = 3'd1;
    step("sel1");
    check_eq("sel1_const", 32'(bus.data_out), 32'h55);
    bus.sel = 3'd2;
    step("sel2");
    check_eq("sel2_const", 32'(bus.data_out), 32'hFF);

    drive(3'd5, 8'h11, 8'h22, 8'h33);
    step("illegal");
    check_eq("illegal_hold", 32'(bus.data_out), 32'hFF);
    check_eq("illegal_flag", 32'(bus.sel_err), 32'h1);
    bus.sel = 3'd0;
    step("recover");
    check_eq("recover_const", 32'(bus.data_out), 32'h11);

    // Data change on the selected source between edges stays invisible until the edge.
    drive(3'd1, 8'h01, 8'h00, 8'h02);
    step("lat_load");
    #2 bus.d1 = 8'h3C;
    #1 check_outs("lat_hold");
    step("lat_next");
    check_eq("lat_const", 32'(bus.data_out), 32'h3C);

    // Mid-operation reset, including an edge that lands while reset is held.
    drive(3'd2, 8'h10, 8'h20, 8'hFF);
    step("pre_rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_data = '0;
    exp_err  = 1'b0;
    check_outs("mid_rst");
    step("rst_held");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst");
    check_eq("post_rst_const", 32'(bus.data_out), 32'hFF);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = ($urandom_range(24) == 0);
      // Bias towards legal codes so data actually moves.
      if ($urandom_range(3) == 0) bus.sel = 3'($urandom_range(7, 3));
      else                         bus.sel = 3'($urandom_range(2));
      bus.d0 = 8'($urandom);
      bus.d1 = 8'($urandom);
      bus.d2 = 8'($urandom);
      if (rst) begin
        #1;
        exp_data = '0;
        exp_err  = 1'b0;
        check_outs("rnd_async_rst");
      end
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
